// File: rtl/pc_pkg.sv
// Shared constants, address type and next-PC source selector for the
// fetch-stage program counter.
package pc_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  localparam int INSN_BYTES  = 4;
  localparam int CINSN_BYTES = 2;

  typedef logic [XLEN_DEFAULT-1:0] addr_t;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_TRAP,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_SEQ
  } next_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: reset > trap > redirect > stall > sequential.
// A redirect whose effective target is not instruction-aligned diverts to the
// trap vector and raises the misalign flag.
// Optional feature: PC_RVC_EN enables 2-byte sequential steps and 2-byte
// redirect alignment (the misalign flag then never fires).
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT)
) (
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] pc,
`ifdef PC_RVC_EN
  input  logic            is_compressed,
`endif
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  next_sel_e       sel;
  logic [XLEN-1:0] eff_target;
  logic [XLEN-1:0] seq_pc;
  logic            target_bad;

  // JALR semantics: bit0 of the target is always discarded.
  assign eff_target = redirect_target & ~XLEN'(1);

`ifdef PC_RVC_EN
  assign seq_pc     = pc + (is_compressed ? XLEN'(CINSN_BYTES) : XLEN'(INSN_BYTES));
  // Bit0 is already cleared, so a 2-byte aligned target is always legal.
  assign target_bad = 1'b0;
`else
  assign seq_pc     = pc + XLEN'(INSN_BYTES);
  assign target_bad = eff_target[1];
`endif

  // Priority encode the source of the next PC.
  always_comb begin
    sel = SEL_SEQ;
    if (!reset)              sel = SEL_RESET;
    else if (trap)           sel = SEL_TRAP;
    else if (redirect_valid) sel = SEL_REDIRECT;
    else if (stall)          sel = SEL_HOLD;
  end

  // Mux the selected source; a misaligned redirect lands on the trap vector.
  always_comb begin
    next_pc  = seq_pc;
    misalign = 1'b0;
    unique case (sel)
      SEL_RESET:    next_pc = RESET_VECTOR;
      SEL_TRAP:     next_pc = TRAP_VECTOR;
      SEL_REDIRECT: begin
        if (target_bad) begin
          next_pc  = TRAP_VECTOR;
          misalign = 1'b1;
        end else begin
          next_pc  = eff_target;
        end
      end
      SEL_HOLD:     next_pc = pc;
      SEL_SEQ:      next_pc = seq_pc;
      default:      next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc.sv
// Fetch-stage program counter register with redirect, trap and stall support,
// plus registered misaligned-redirect reporting.
// Optional feature: PC_RVC_EN adds is_compressed / pc_next_seq for RVC fetch.
module pc
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
`ifdef PC_RVC_EN
  input  logic            is_compressed,
  output logic [XLEN-1:0] pc_next_seq,
`endif
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  logic [XLEN-1:0] next_pc;
  logic            misalign;

  pc_next_sel #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_next_sel (
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .pc              (pc_out),
`ifdef PC_RVC_EN
    .is_compressed   (is_compressed),
`endif
    .next_pc         (next_pc),
    .misalign        (misalign)
  );

  assign pc_plus4 = pc_out + XLEN'(INSN_BYTES);

`ifdef PC_RVC_EN
  assign pc_next_seq = pc_out + (is_compressed ? XLEN'(CINSN_BYTES) : XLEN'(INSN_BYTES));
`endif

  // PC and error reporting registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out        <= RESET_VECTOR;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      pc_out       <= next_pc;
      misalign_err <= misalign;
      if (misalign) misalign_addr <= redirect_target;
    end
  end

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for the program counter (default build).
module tb_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int tests = 0;
  int fails = 0;

  pc dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err),
    .misalign_addr   (misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; trap = 1'b0;

    // Reset
    step();
    check("rst_pc",   pc_out, 32'h0);
    check("rst_err",  32'(misalign_err), 32'h0);
    check("rst_addr", misalign_addr, 32'h0);
    check("rst_p4",   pc_plus4, 32'h4);

    // Sequential advance
    reset = 1'b1;
    step(); check("seq1", pc_out, 32'h4);
    step(); check("seq2", pc_out, 32'h8);
    check("seq2_p4", pc_plus4, 32'hC);
    step(); check("seq3", pc_out, 32'hC);
    step(); check("seq4", pc_out, 32'h10);

    // Stall
    stall = 1'b1;
    step(); check("stall1", pc_out, 32'h10);
    step(); check("stall2", pc_out, 32'h10);
    step(); check("stall3", pc_out, 32'h10);
    stall = 1'b0;
    step(); check("unstall", pc_out, 32'h14);

    // Redirect with bit0 set: cleared, aligned
    redirect_valid = 1'b1; redirect_target = 32'h0000_2001;
    step();
    check("rd_2001_pc",  pc_out, 32'h2000);
    check("rd_2001_err", 32'(misalign_err), 32'h0);

    // Misaligned redirect
    redirect_target = 32'h0000_2002;
    step();
    check("mis_pc",   pc_out, 32'h100);
    check("mis_err",  32'(misalign_err), 32'h1);
    check("mis_addr", misalign_addr, 32'h2002);
    redirect_valid = 1'b0;
    step();
    check("mis_pulse_pc",   pc_out, 32'h104);
    check("mis_pulse_err",  32'(misalign_err), 32'h0);
    check("mis_addr_hold",  misalign_addr, 32'h2002);

    // Trap beats redirect and stall
    trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3000; stall = 1'b1;
    step(); check("trap_prio", pc_out, 32'h100);
    // Redirect beats stall
    trap = 1'b0;
    step(); check("rd_over_stall", pc_out, 32'h3000);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check("after_rd", pc_out, 32'h3004);

    // Trap alone
    trap = 1'b1;
    step(); check("trap_only", pc_out, 32'h100);
    trap = 1'b0;

    // Wrap-around
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    check("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check("wrap_p4", pc_plus4, 32'h0);
    redirect_valid = 1'b0;
    step(); check("wrap_seq", pc_out, 32'h0);

    // Mid-run reset overrides a (misaligned) redirect
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step(); check("to_40", pc_out, 32'h40);
    reset = 1'b0; redirect_target = 32'h2002;
    step();
    check("mid_rst_pc",   pc_out, 32'h0);
    check("mid_rst_err",  32'(misalign_err), 32'h0);
    check("mid_rst_addr", misalign_addr, 32'h2002 & 32'h0);
    reset = 1'b1; redirect_valid = 1'b0;
    step(); check("post_rst", pc_out, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
